// File: rtl/datapath_sequencer_if.sv
// ============================================================================
//  Module      : datapath_sequencer_if
//  Description : Bundle of the control strobes between datapath_sequencer
//                and DataPath, plus the run request and the memory-ready
//                handshake.
//                master : sequencer side (drives strobes, reads IR/run/rdy)
//                slave  : DataPath / environment side
//  Signals     : run, mem_rdy, IR[31:0]          -> sequencer
//                Rin[31:0], Rout[31:0], IRin, MARin, RYin, MDRread, RZout,
//                RBin, PCjump, ALUControl[15:0], busy, halted, illegal,
//                instr_done                       <- sequencer
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface datapath_sequencer_if;
   logic        run;
   logic        mem_rdy;
   logic [31:0] IR;
   logic [31:0] Rin;
   logic [31:0] Rout;
   logic        IRin;
   logic        MARin;
   logic        RYin;
   logic        MDRread;
   logic        RZout;
   logic        RBin;
   logic        PCjump;
   logic [15:0] ALUControl;
   logic        busy;
   logic        halted;
   logic        illegal;
   logic        instr_done;

   modport master (
      input  run, mem_rdy, IR,
      output Rin, Rout, IRin, MARin, RYin, MDRread, RZout, RBin, PCjump,
             ALUControl, busy, halted, illegal, instr_done
   );

   modport slave (
      output run, mem_rdy, IR,
      input  Rin, Rout, IRin, MARin, RYin, MDRread, RZout, RBin, PCjump,
             ALUControl, busy, halted, illegal, instr_done
   );
endinterface

`default_nettype wire

// File: rtl/datapath_sequencer.sv
// ============================================================================
//  Module      : datapath_sequencer
//  Description : Hardwired control unit for DataPath. Fetch (T0-T2), decode
//                in T3, execute (T3-T5) of three-register ALU instructions,
//                memory-ready wait in T1, halt and illegal-opcode flagging.
//  Ports       : clock  - rising-edge clock
//                clear  - synchronous active-low reset
//                bus    - datapath_sequencer_if.master (strobes, run,
//                         mem_rdy, IR, status flags)
//  Parameters  : ALU_INCPC - ALUControl used in T0 to form PC+1
//                HALT_OP   - opcode that stops the sequencer
//  Macro       : SEQ_SINGLE_STEP_EN - when defined, T5 and illegal-opcode T3
//                return to IDLE so each run pulse executes one instruction.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module datapath_sequencer #(
   parameter logic [15:0] ALU_INCPC = 16'd0,
   parameter logic [4:0]  HALT_OP   = 5'd31
) (
   input  wire logic             clock,
   input  wire logic             clear,
   datapath_sequencer_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_T4   = 3'd5,
      S_T5   = 3'd6,
      S_HALT = 3'd7
   } state_t;

   // Where execution goes after a finished or rejected instruction.
`ifdef SEQ_SINGLE_STEP_EN
   localparam state_t AFTER_INSTR = S_IDLE;
`else
   localparam state_t AFTER_INSTR = S_T0;
`endif

   // Bus bit positions of the special registers in Rin/Rout.
   localparam int ZLOW_BIT = 19;
   localparam int PC_BIT   = 20;
   localparam int MDR_BIT  = 21;

   state_t state;
   state_t state_nxt;

   logic [4:0] opcode;
   logic [3:0] ra;
   logic [3:0] rb;
   logic [3:0] rc;
   logic       is_halt;
   logic       is_alu;
   logic       unused_ir;

   assign opcode    = bus.IR[31:27];
   assign ra        = bus.IR[26:23];
   assign rb        = bus.IR[22:19];
   assign rc        = bus.IR[18:15];
   assign unused_ir = ^bus.IR[14:0];

   // Halt is checked first so a HALT_OP inside 0-15 still halts.
   assign is_halt = (opcode == HALT_OP);
   assign is_alu  = !is_halt && (opcode[4] == 1'b0);

   always_ff @(posedge clock) begin
      if (!clear) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      bus.Rin        = 32'd0;
      bus.Rout       = 32'd0;
      bus.IRin       = 1'b0;
      bus.MARin      = 1'b0;
      bus.RYin       = 1'b0;
      bus.MDRread    = 1'b0;
      bus.RZout      = 1'b0;
      bus.RBin       = 1'b0;
      bus.PCjump     = 1'b0;
      bus.ALUControl = 16'd0;
      bus.busy       = 1'b1;
      bus.halted     = 1'b0;
      bus.illegal    = 1'b0;
      bus.instr_done = 1'b0;

      case (state)
         S_IDLE: begin
            bus.busy = 1'b0;
            if (bus.run) state_nxt = S_T0;
         end
         S_T0: begin
            bus.Rout[PC_BIT]  = 1'b1;
            bus.MARin         = 1'b1;
            bus.Rin[ZLOW_BIT] = 1'b1;
            bus.ALUControl    = ALU_INCPC;
            state_nxt         = S_T1;
         end
         S_T1: begin
            // MDR keeps loading through wait cycles; PC is loaded only on
            // the ready cycle so it is written once per fetch.
            bus.Rout[ZLOW_BIT] = 1'b1;
            bus.MDRread        = 1'b1;
            bus.Rin[MDR_BIT]   = 1'b1;
            bus.Rin[PC_BIT]    = bus.mem_rdy;
            if (bus.mem_rdy) state_nxt = S_T2;
         end
         S_T2: begin
            bus.Rout[MDR_BIT] = 1'b1;
            bus.IRin          = 1'b1;
            state_nxt         = S_T3;
         end
         S_T3: begin
            bus.Rout = 32'd1 << rb;
            bus.RYin = 1'b1;
            if (is_halt) begin
               state_nxt = S_HALT;
            end else if (is_alu) begin
               state_nxt = S_T4;
            end else begin
               bus.illegal = 1'b1;
               state_nxt   = AFTER_INSTR;
            end
         end
         S_T4: begin
            bus.Rout          = 32'd1 << rc;
            bus.Rin[ZLOW_BIT] = 1'b1;
            bus.ALUControl    = {11'b0, opcode};
            state_nxt         = S_T5;
         end
         S_T5: begin
            bus.Rout[ZLOW_BIT] = 1'b1;
            bus.Rin            = 32'd1 << ra;
            bus.instr_done     = 1'b1;
            state_nxt          = AFTER_INSTR;
         end
         S_HALT: begin
            bus.busy   = 1'b0;
            bus.halted = 1'b1;
            if (bus.run) state_nxt = S_T0;
         end
         default: begin
            bus.busy  = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
// ============================================================================
//  Module      : tb_datapath_sequencer
//  Description : Scoreboard bench for datapath_sequencer. Each driven cycle
//                pushes the expected output vector; a negedge monitor pops
//                and compares it with the DUT outputs.
//  Macro       : SEQ_SINGLE_STEP_EN (same meaning as in the design)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_datapath_sequencer;

`ifdef SEQ_SINGLE_STEP_EN
   localparam bit SS = 1'b1;
`else
   localparam bit SS = 1'b0;
`endif

   logic clock;
   logic clear;

   datapath_sequencer_if bus_if ();

   datapath_sequencer #(
      .ALU_INCPC (16'd0),
      .HALT_OP   (5'd31)
   ) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus_if.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // {Rin, Rout, {IRin,MARin,RYin,MDRread,RZout,RBin,PCjump}, ALUControl,
   //  {busy,halted,illegal,instr_done}}
   logic [90:0] got;
   assign got = {bus_if.Rin, bus_if.Rout,
                 bus_if.IRin, bus_if.MARin, bus_if.RYin, bus_if.MDRread,
                 bus_if.RZout, bus_if.RBin, bus_if.PCjump,
                 bus_if.ALUControl,
                 bus_if.busy, bus_if.halted, bus_if.illegal, bus_if.instr_done};

   int n_vec = 0;
   int n_err = 0;

   logic [90:0] q_exp[$];
   string       q_tag[$];

   task automatic check(input string tag, input logic [90:0] obs, input logic [90:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [90:0] mk(input logic [31:0] rin, input logic [31:0] rout,
                                      input logic [6:0] strb, input logic [15:0] alu,
                                      input logic [3:0] flg);
      return {rin, rout, strb, alu, flg};
   endfunction

   function automatic logic [31:0] bit_of(input int n);
      return 32'd1 << n;
   endfunction

   function automatic logic [90:0] e_idle();
      return mk(32'd0, 32'd0, 7'b0, 16'd0, 4'b0000);
   endfunction
   function automatic logic [90:0] e_t0();
      return mk(bit_of(19), bit_of(20), 7'b0100000, 16'd0, 4'b1000);
   endfunction
   function automatic logic [90:0] e_t1(input logic rdy);
      return mk(bit_of(21) | (rdy ? bit_of(20) : 32'd0), bit_of(19), 7'b0001000, 16'd0, 4'b1000);
   endfunction
   function automatic logic [90:0] e_t2();
      return mk(32'd0, bit_of(21), 7'b1000000, 16'd0, 4'b1000);
   endfunction
   function automatic logic [90:0] e_t3(input int rb, input logic ill);
      return mk(32'd0, bit_of(rb), 7'b0010000, 16'd0, {1'b1, 1'b0, ill, 1'b0});
   endfunction
   function automatic logic [90:0] e_t4(input int rc, input int op);
      return mk(bit_of(19), bit_of(rc), 7'b0, 16'(op), 4'b1000);
   endfunction
   function automatic logic [90:0] e_t5(input int ra);
      return mk(bit_of(ra), bit_of(19), 7'b0, 16'd0, 4'b1001);
   endfunction
   function automatic logic [90:0] e_halt();
      return mk(32'd0, 32'd0, 7'b0, 16'd0, 4'b0100);
   endfunction

   // One cycle: wait for the edge that enters the state, drive inputs for
   // this cycle, and record what the outputs must be during it.
   task automatic cyc(input logic r, input logic m, input logic c,
                      input logic [90:0] e, input string tag);
      @(posedge clock);
      #1;
      bus_if.run     = r;
      bus_if.mem_rdy = m;
      clear          = c;
      q_exp.push_back(e);
      q_tag.push_back(tag);
   endtask

   always @(negedge clock) begin
      if (q_exp.size() > 0) begin
         check(q_tag.pop_front(), got, q_exp.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      clear          = 1'b0;
      bus_if.run     = 1'b0;
      bus_if.mem_rdy = 1'b0;
      bus_if.IR      = 32'd0;

      // Reset state
      cyc(0, 0, 0, e_idle(), "rst_idle");
      cyc(0, 0, 0, e_idle(), "rst_hold");

      // ROR r7 <- r6, r4
      bus_if.IR = 32'h43B20000;
      cyc(1, 1, 1, e_idle(), "idle_run");
      cyc(0, 1, 1, e_t0(), "ror_t0");
      cyc(0, 1, 1, e_t1(1'b1), "ror_t1");
      cyc(0, 1, 1, e_t2(), "ror_t2");
      cyc(0, 1, 1, e_t3(6, 1'b0), "ror_t3");
      cyc(0, 1, 1, e_t4(4, 8), "ror_t4");
      cyc(0, 1, 1, e_t5(7), "ror_t5");
      if (SS) cyc(1, 1, 1, e_idle(), "ss_idle_after_t5");

      // Memory wait, then HALT instruction
      cyc(0, 0, 1, e_t0(), "wait_t0");
      bus_if.IR = 32'hF8000000;
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, e_t1(1'b0), "wait_t1_low");
      cyc(0, 1, 1, e_t1(1'b1), "wait_t1_rdy");
      cyc(0, 1, 1, e_t2(), "wait_t2");
      cyc(0, 1, 1, e_t3(0, 1'b0), "halt_t3");
      cyc(0, 1, 1, e_halt(), "halt_1");
      cyc(1, 1, 1, e_halt(), "halt_2");

      // Illegal opcode 16
      cyc(0, 1, 1, e_t0(), "ill_t0");
      bus_if.IR = 32'h80000000;
      cyc(0, 1, 1, e_t1(1'b1), "ill_t1");
      cyc(0, 1, 1, e_t2(), "ill_t2");
      cyc(0, 1, 1, e_t3(0, 1'b1), "ill_t3");
      if (SS) cyc(1, 1, 1, e_idle(), "ss_idle_after_ill");

      // Reset in the middle of T4
      cyc(0, 1, 1, e_t0(), "rst_t0");
      bus_if.IR = 32'h43B20000;
      cyc(0, 1, 1, e_t1(1'b1), "rst_t1");
      cyc(0, 1, 1, e_t2(), "rst_t2");
      cyc(0, 1, 1, e_t3(6, 1'b0), "rst_t3");
      cyc(0, 1, 0, e_t4(4, 8), "rst_t4");
      cyc(1, 1, 1, e_idle(), "rst_cleared");

      // Re-run: opcode 3 with ra=rb=rc=5
      cyc(0, 1, 1, e_t0(), "rerun_t0");
      bus_if.IR = {5'd3, 4'd5, 4'd5, 4'd5, 15'd0};
      cyc(0, 1, 1, e_t1(1'b1), "same_t1");
      cyc(0, 1, 1, e_t2(), "same_t2");
      cyc(0, 1, 1, e_t3(5, 1'b0), "same_t3");
      cyc(0, 1, 1, e_t4(5, 3), "same_t4");
      cyc(0, 1, 1, e_t5(5), "same_t5");
      cyc(0, 1, 1, SS ? e_idle() : e_t0(), "tail");

      repeat (3) @(posedge clock);
      check("drain", 91'(q_exp.size()), 91'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
